// File: rtl/esp_uart_txq.sv
`default_nettype none
// ============================================================================
// Module      : esp_uart_txq
// Description : Buffered UART transmit path: byte FIFO feeding an 8N1
//               serializer with CTS flow control and break generation.
// Revision    : 1.0 - initial release
// ============================================================================
module esp_uart_txq #(
    parameter int unsigned BAUD_DIV   = 25,
    parameter int unsigned FIFO_AW    = 4,
    parameter int unsigned BREAK_BITS = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] wrdata,
    input  logic       wr_en,
    output logic       txfifo_full,
    output logic       txfifo_empty,
    output logic       txfifo_overflow,
    input  logic       tx_break,
    output logic       tx_idle,
    output logic       uart_txd,
    input  logic       uart_cts
);

    localparam int unsigned      c_DEPTH    = 2 ** FIFO_AW;
    localparam int unsigned      c_TW       = $clog2(BAUD_DIV);
    localparam int unsigned      c_BW       = $clog2(BREAK_BITS + 1);
    localparam logic [c_TW-1:0]  c_TMAX     = c_TW'(BAUD_DIV - 1);
    localparam logic [c_BW-1:0]  c_BRK_LAST = c_BW'(BREAK_BITS - 1);
    localparam logic [FIFO_AW:0] c_FULL     = (FIFO_AW + 1)'(c_DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;
    localparam logic [2:0] S_MARK  = 3'd5;

    logic [7:0]         r_mem [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;
    logic               r_cts_meta;
    logic               r_cts_s;
    logic [2:0]         r_state;
    logic [c_TW-1:0]    r_timer;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic [c_BW-1:0]    r_brk_cnt;
    logic               r_txd;

    logic w_full;
    logic w_empty;
    logic w_tick;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == c_FULL);
    assign w_empty = (r_count == '0);
    assign w_tick  = (r_timer == '0);

    // A frame may start from IDLE or directly off the last STOP cycle so that
    // queued bytes go out back-to-back with no idle gap.
    assign w_pop  = !w_empty && !r_cts_s && !tx_break &&
                    ((r_state == S_IDLE) || ((r_state == S_STOP) && w_tick));
    assign w_push = wr_en && (!w_full || w_pop);

    assign txfifo_full     = w_full;
    assign txfifo_empty    = w_empty;
    assign txfifo_overflow = r_overflow;
    assign tx_idle         = (r_state == S_IDLE) && w_empty;
    assign uart_txd        = r_txd;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wrdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_cts_meta <= 1'b0;
            r_cts_s    <= 1'b0;
        end else begin
            r_cts_meta <= uart_cts;
            r_cts_s    <= r_cts_meta;
            r_overflow <= wr_en && !w_push;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_brk_cnt <= '0;
            r_txd     <= 1'b1;
        end else begin
            if (!w_tick) begin
                r_timer <= r_timer - c_TW'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (tx_break) begin
                        r_state   <= S_BREAK;
                        r_txd     <= 1'b0;
                        r_timer   <= c_TMAX;
                        r_brk_cnt <= '0;
                    end else if (w_pop) begin
                        r_state <= S_START;
                        r_txd   <= 1'b0;
                        r_timer <= c_TMAX;
                        r_shift <= r_mem[r_rd_ptr];
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_state   <= S_DATA;
                        r_txd     <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                        r_timer   <= c_TMAX;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_timer <= c_TMAX;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_txd   <= 1'b1;
                        end else begin
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        if (w_pop) begin
                            r_state <= S_START;
                            r_txd   <= 1'b0;
                            r_timer <= c_TMAX;
                            r_shift <= r_mem[r_rd_ptr];
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_BREAK: begin
                    // Release is only honoured on a bit boundary once the
                    // minimum break length has been served.
                    if (w_tick) begin
                        r_timer <= c_TMAX;
                        if ((r_brk_cnt >= c_BRK_LAST) && !tx_break) begin
                            r_state <= S_MARK;
                            r_txd   <= 1'b1;
                        end else if (r_brk_cnt < c_BRK_LAST) begin
                            r_brk_cnt <= r_brk_cnt + c_BW'(1);
                        end
                    end
                end
                S_MARK: begin
                    if (w_tick) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_esp_uart_txq.sv
`default_nettype none
// ============================================================================
// Module      : tb_esp_uart_txq
// Description : Scoreboard bench for esp_uart_txq; a serial-line receiver
//               decodes frames and compares them against queued bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_esp_uart_txq;

    localparam int unsigned BAUD_DIV   = 4;
    localparam int unsigned FIFO_AW    = 2;
    localparam int unsigned BREAK_BITS = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] wrdata = 8'h00;
    logic       wr_en = 1'b0;
    logic       tx_break = 1'b0;
    logic       uart_cts = 1'b0;
    logic       txfifo_full;
    logic       txfifo_empty;
    logic       txfifo_overflow;
    logic       tx_idle;
    logic       uart_txd;

    int         checks = 0;
    int         failures = 0;
    longint     cyc = 0;
    logic [7:0] exp_q[$];
    longint     start_q[$];
    bit         mon_en = 1'b0;

    esp_uart_txq #(
        .BAUD_DIV  (BAUD_DIV),
        .FIFO_AW   (FIFO_AW),
        .BREAK_BITS(BREAK_BITS)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .wrdata         (wrdata),
        .wr_en          (wr_en),
        .txfifo_full    (txfifo_full),
        .txfifo_empty   (txfifo_empty),
        .txfifo_overflow(txfifo_overflow),
        .tx_break       (tx_break),
        .tx_idle        (tx_idle),
        .uart_txd       (uart_txd),
        .uart_cts       (uart_cts)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Serial receiver: samples mid-bit and pops the scoreboard per frame.
    initial begin : monitor
        logic       prev;
        logic [9:0] fr;
        logic [7:0] e;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (mon_en && prev && !uart_txd) begin
                start_q.push_back(cyc);
                repeat (BAUD_DIV / 2) @(negedge clk);
                fr[0] = uart_txd;
                for (int k = 1; k < 10; k++) begin
                    repeat (BAUD_DIV) @(negedge clk);
                    fr[k] = uart_txd;
                end
                repeat (BAUD_DIV - BAUD_DIV / 2 - 1) @(negedge clk);
                if (mon_en) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_frame", {54'd0, fr}, 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_start_bit", fr[0], 1'b0);
                        chk("frame_byte", fr[8:1], e);
                        chk("frame_stop_bit", fr[9], 1'b1);
                    end
                end
            end
            prev = uart_txd;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && tx_idle === 1'b1) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, n < budget, 1'b1);
    endtask

    task automatic count_lows(input int cycles, output int lows);
        lows = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (uart_txd !== 1'b1) lows++;
        end
    endtask

    initial begin : stim
        int         n;
        int         lows;
        int         h;
        int         k;
        bit         done;
        logic [7:0] d [5];
        int         holds [3];

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_txd", uart_txd, 1'b1);
        chk("rst_full", txfifo_full, 1'b0);
        chk("rst_empty", txfifo_empty, 1'b1);
        chk("rst_overflow", txfifo_overflow, 1'b0);
        chk("rst_idle", tx_idle, 1'b1);
        mon_en = 1'b1;

        // Single byte: latency to start bit and total frame length.
        exp_q.push_back(8'hA5);
        wr_en = 1'b1; wrdata = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        chk("t1_txd_at_write", uart_txd, 1'b1);
        @(negedge clk);
        chk("t1_txd_low_after_write", uart_txd, 1'b0);
        repeat (39) @(negedge clk);
        chk("t1_idle_cycle40", tx_idle, 1'b0);
        @(negedge clk);
        chk("t1_idle_cycle41", tx_idle, 1'b1);
        wait_drain("t1", 20);

        // Back-to-back frames must abut exactly.
        start_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        wr_en = 1'b1; wrdata = 8'h00;
        @(negedge clk);
        wrdata = 8'hFF;
        @(negedge clk);
        wr_en = 1'b0;
        wait_drain("t2", 200);
        chk("t2_frames", start_q.size(), 2);
        if (start_q.size() == 2) chk("t2_gap", start_q[1] - start_q[0], 10 * BAUD_DIV);

        // Fill while CTS blocks, then overflow.
        uart_cts = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) d[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) exp_q.push_back(d[i]);
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wrdata = d[i];
            @(negedge clk);
            if (i == 2) chk("t3_not_full_3", txfifo_full, 1'b0);
            if (i == 3) chk("t3_full_4", txfifo_full, 1'b1);
            if (i == 3) chk("t3_no_ovf_4", txfifo_overflow, 1'b0);
            if (i == 4) chk("t3_ovf_pulse", txfifo_overflow, 1'b1);
        end
        wr_en = 1'b0;
        @(negedge clk);
        chk("t3_ovf_cleared", txfifo_overflow, 1'b0);
        count_lows(20, lows);
        chk("t3_cts_holds_line", lows, 0);
        uart_cts = 1'b0;
        wait_drain("t3", 300);
        chk("t3_empty_after", txfifo_empty, 1'b1);

        // CTS asserted mid-frame: current frame finishes, next one waits.
        d[0] = 8'($urandom); d[1] = 8'($urandom);
        exp_q.push_back(d[0]);
        exp_q.push_back(d[1]);
        wr_en = 1'b1; wrdata = d[0];
        @(negedge clk);
        wrdata = d[1];
        @(negedge clk);
        wr_en = 1'b0;
        repeat (10) @(negedge clk);
        uart_cts = 1'b1;
        n = 0;
        while (exp_q.size() > 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_frame1_done", n < 200, 1'b1);
        count_lows(30, lows);
        chk("t4_cts_blocks_frame2", lows, 0);
        chk("t4_byte_still_queued", txfifo_empty, 1'b0);
        uart_cts = 1'b0;
        n = 0;
        while (uart_txd === 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_resume_latency_2to3", (n >= 2) && (n <= 3), 1'b1);
        wait_drain("t4", 200);

        // Break: low time is the whole bit times covering the request, min BREAK_BITS.
        mon_en = 1'b0;
        holds[0] = 1;
        holds[1] = 30;
        holds[2] = int'($urandom_range(1, 40));
        for (int j = 0; j < 3; j++) begin
            h = holds[j];
            k = (h + BAUD_DIV - 1) / BAUD_DIV;
            if (k < BREAK_BITS) k = BREAK_BITS;
            @(negedge clk);
            tx_break = 1'b1;
            lows = 0; n = 0; done = 1'b0;
            while (!done && n < 300) begin
                @(negedge clk);
                n++;
                if (n == h) tx_break = 1'b0;
                if (uart_txd === 1'b0) lows++;
                else if (lows > 0) done = 1'b1;
            end
            tx_break = 1'b0;
            chk($sformatf("t5_break_len_hold%0d", h), lows, k * BAUD_DIV);
            chk("t5_mark_not_idle", tx_idle, 1'b0);
            repeat (BAUD_DIV) @(negedge clk);
            chk("t5_idle_after_mark", tx_idle, 1'b1);
        end
        mon_en = 1'b1;

        // Random traffic with CTS jitter.
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 30)) begin
                @(negedge clk);
                if ($urandom_range(0, 7) == 0) uart_cts = ~uart_cts;
            end
            if (txfifo_full === 1'b0) begin
                d[0] = 8'($urandom);
                exp_q.push_back(d[0]);
                wr_en = 1'b1; wrdata = d[0];
                @(negedge clk);
                wr_en = 1'b0;
            end
        end
        uart_cts = 1'b0;
        wait_drain("rand", 24 * 10 * BAUD_DIV + 200);

        // Reset mid-DATA with bytes queued.
        mon_en = 1'b0;
        wr_en = 1'b1; wrdata = 8'h00;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            wrdata = 8'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
        repeat (8) @(negedge clk);
        chk("t6_txd_low_in_data", uart_txd, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk("t6_txd_async_high", uart_txd, 1'b1);
        chk("t6_empty_async", txfifo_empty, 1'b1);
        chk("t6_idle_async", tx_idle, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        count_lows(60, lows);
        chk("t6_no_frame_after_reset", lows, 0);
        chk("t6_empty_after", txfifo_empty, 1'b1);
        exp_q.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
